vic_wb_buffer: RTL and testbench
================================

VIC_WB_BUFFER -- requirements
Module: vic_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of writeback entries (power of two, >= 2).
REQ-002 Parameters NUM_SET_BITS and NUM_TAG_BITS: codebase-wide cache set-index and tag widths.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset==0 clears all state immediately.
REQ-005 fired_valid  input  1  the victim cache is evicting a line this cycle.
REQ-006 fired_tag  input  NUM_TAG_BITS  tag of the evicted line.
REQ-007 fired_set  input  NUM_SET_BITS  set index of the evicted line.
REQ-008 fired_data  input  64  data of the evicted line.
REQ-009 fired_dirty  input  1  the evicted line is modified.
REQ-010 fired_ready  output  1  buffer can accept an eviction this cycle.
REQ-011 mem_req_valid  output  1  store request to memory is pending.
REQ-012 mem_addr  output  64  store address, {zero-pad, tag, set, 3'b000}.
REQ-013 mem_data  output  64  store data.
REQ-014 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-015 lookup_tag, lookup_set  input  NUM_TAG_BITS, NUM_SET_BITS  miss address probed by the cache controller.
REQ-016 lookup_hit  output  1  a buffered line matches the probe.
REQ-017 lookup_data  output  64  data of the matching line.
REQ-018 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-019 Storage is a circular FIFO of DEPTH entries, each holding {tag, set, data}, with head and tail pointers that wrap modulo DEPTH.
REQ-020 fired_ready SHALL equal (count != DEPTH); there is no same-cycle bypass when the buffer is full.
REQ-021 An eviction is enqueued at the tail on a rising edge when fired_valid && fired_ready && fired_dirty.
REQ-022 An eviction with fired_dirty==0 is dropped, and state is unchanged.
REQ-023 A write-path FSM has two states: IDLE (mem_req_valid=0) and SEND (mem_req_valid=1, mem_addr/mem_data driven from the head entry).
REQ-024 IDLE -> SEND on the edge where count becomes nonzero; the first request is visible one cycle after the enqueue edge.
REQ-025 In SEND, the head entry, mem_addr and mem_data SHALL stay stable until mem_req_ready==1.
REQ-026 A SEND cycle with mem_req_ready==1 dequeues the head on that edge; the FSM stays in SEND if entries remain, otherwise it goes to IDLE.
REQ-027 An enqueue and a dequeue on the same edge leave count unchanged, and both pointers advance.
REQ-028 An enqueue into a buffer holding one entry that is being dequeued in the same cycle keeps the FSM in SEND with the new head.
REQ-029 lookup_hit/lookup_data are combinational over all occupied entries; when several entries match, the newest wins.
REQ-030 The head entry is probe-visible until the edge that dequeues it.
REQ-031 An entry being enqueued is probe-visible only from the following cycle.
REQ-032 lookup_data SHALL be 0 when lookup_hit==0.
REQ-033 Duplicate tag/set entries are all retained and all written to memory in FIFO order.

Reset
REQ-034 While reset==0: count=0, pointers=0, FSM=IDLE, fired_ready=1, mem_req_valid=0, mem_addr=0, mem_data=0, lookup_hit=0, lookup_data=0.
REQ-035 Reset asserted mid-SEND aborts the request immediately and discards all entries; nothing is replayed after reset deasserts.

Verification
REQ-036 Reset: reset=0 asynchronously between edges -> all outputs at REQ-034 values within the same cycle, count=0.
REQ-037 Single writeback: enqueue a dirty line with tag=5, set=2, data=64'hDEAD; the next cycle shows mem_req_valid=1 and mem_addr={tag 5, set 2, 3'b000}. Hold mem_req_ready=0 for 3 cycles -> outputs stable. Then assert ready -> count=0 and IDLE.
REQ-038 Full and wrap: enqueue 4 dirty lines with memory stalled -> fired_ready=0 and a 5th eviction is ignored. Drain -> addresses emerge in order. Refill to full -> pointer wrap is correct.
REQ-039 Clean drop: fired_dirty=0 with fired_valid=1 -> count unchanged and mem_req_valid stays 0.
REQ-040 Forwarding: two entries with the same tag/set but data A then B -> probe returns B. After the first dequeue, the probe still returns B. After both are dequeued, lookup_hit=0.
REQ-041 Simultaneous events: count=4 with dequeue and a dirty fired_valid on the same edge -> fired_ready=0, so the new line is rejected and count=3. At count=1, enqueue plus dequeue -> count=1, FSM stays in SEND, and the new head is driven on mem_addr.

Source files
------------

// File: rtl/vic_wb_buffer.sv
// Writeback buffer behind the victim cache: dirty evictions queue in a circular FIFO
// and drain to memory one store at a time. Buffered lines stay probe-visible for miss forwarding.
module vic_wb_buffer #(
    parameter int DEPTH        = 4,
    parameter int NUM_SET_BITS = 6,
    parameter int NUM_TAG_BITS = 20,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fired_valid,
    input  logic [NUM_TAG_BITS-1:0] fired_tag,
    input  logic [NUM_SET_BITS-1:0] fired_set,
    input  logic [63:0]             fired_data,
    input  logic                    fired_dirty,
    output logic                    fired_ready,
    output logic                    mem_req_valid,
    output logic [63:0]             mem_addr,
    output logic [63:0]             mem_data,
    input  logic                    mem_req_ready,
    input  logic [NUM_TAG_BITS-1:0] lookup_tag,
    input  logic [NUM_SET_BITS-1:0] lookup_set,
    output logic                    lookup_hit,
    output logic [63:0]             lookup_data,
    output logic [CW-1:0]           count
);
    localparam int AW = NUM_TAG_BITS + NUM_SET_BITS + 3;

    typedef enum logic {IDLE, SEND} state_t;

    logic [NUM_TAG_BITS-1:0] tag_q  [DEPTH];
    logic [NUM_SET_BITS-1:0] set_q  [DEPTH];
    logic [63:0]             data_q [DEPTH];
    logic [PW-1:0]           head, tail;
    logic [CW-1:0]           count_nxt;
    state_t                  state;
    logic                    enq, deq;

    // No bypass when full: a full buffer refuses even if the head drains this cycle.
    assign fired_ready = (count != CW'(DEPTH));
    assign enq         = fired_valid & fired_ready & fired_dirty;
    assign deq         = (state == SEND) & mem_req_ready;
    assign count_nxt   = count + CW'(enq) - CW'(deq);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= IDLE;
            mem_req_valid <= 1'b0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            count <= count_nxt;
            case (state)
                IDLE: if (count_nxt != '0) begin
                    state         <= SEND;
                    mem_req_valid <= 1'b1;
                end
                SEND: if (count_nxt == '0) begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Entry payload needs no reset; occupancy is tracked by head/count alone.
    always_ff @(posedge clock) begin
        if (enq) begin
            tag_q[tail]  <= fired_tag;
            set_q[tail]  <= fired_set;
            data_q[tail] <= fired_data;
        end
    end

    assign mem_addr = (state == SEND) ?
                      {{(64-AW){1'b0}}, tag_q[head], set_q[head], 3'b000} : '0;
    assign mem_data = (state == SEND) ? data_q[head] : '0;

    // Walk oldest to newest so the newest matching entry overwrites older hits.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && tag_q[idx] == lookup_tag && set_q[idx] == lookup_set) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_vic_wb_buffer.sv
// Bench for vic_wb_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vic_wb_buffer;
    localparam int DEPTH = 4;
    localparam int SB    = 6;
    localparam int TB    = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          fired_valid = 1'b0;
    logic [TB-1:0] fired_tag = '0;
    logic [SB-1:0] fired_set = '0;
    logic [63:0]   fired_data = '0;
    logic          fired_dirty = 1'b0;
    logic          fired_ready;
    logic          mem_req_valid;
    logic [63:0]   mem_addr, mem_data;
    logic          mem_req_ready = 1'b0;
    logic [TB-1:0] lookup_tag = '0;
    logic [SB-1:0] lookup_set = '0;
    logic          lookup_hit;
    logic [63:0]   lookup_data;
    logic [CW-1:0] count;

    vic_wb_buffer #(.DEPTH(DEPTH), .NUM_SET_BITS(SB), .NUM_TAG_BITS(TB)) dut (
        .clock(clock), .reset(reset),
        .fired_valid(fired_valid), .fired_tag(fired_tag), .fired_set(fired_set),
        .fired_data(fired_data), .fired_dirty(fired_dirty), .fired_ready(fired_ready),
        .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_req_ready(mem_req_ready), .lookup_tag(lookup_tag), .lookup_set(lookup_set),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data), .count(count)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    bit done   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    typedef struct {
        logic [TB-1:0] tag;
        logic [SB-1:0] set;
        logic [63:0]   data;
    } ent_t;
    ent_t q[$];

    function automatic logic [63:0] addr_of(input logic [TB-1:0] t, input logic [SB-1:0] s);
        return (64'(t) << (SB + 3)) | (64'(s) << 3);
    endfunction

    // Reference model: a plain FIFO; the buffer is "sending" whenever it is non-empty.
    always @(posedge clock or negedge reset) begin
        if (!reset) q.delete();
        else begin
            bit do_deq, do_enq;
            do_deq = (q.size() > 0) && mem_req_ready;
            do_enq = fired_valid && fired_dirty && (q.size() < DEPTH);
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back('{fired_tag, fired_set, fired_data});
        end
    end

    always @(negedge clock) begin
        if (!done) begin
            logic        e_hit;
            logic [63:0] e_ld;
            e_hit = 0;
            e_ld  = '0;
            for (int i = q.size() - 1; i >= 0; i--)
                if (!e_hit && q[i].tag == lookup_tag && q[i].set == lookup_set) begin
                    e_hit = 1;
                    e_ld  = q[i].data;
                end
            chk("m_fired_ready", 64'(fired_ready), 64'(q.size() < DEPTH));
            chk("m_count", 64'(count), 64'(q.size()));
            chk("m_mem_req_valid", 64'(mem_req_valid), 64'(q.size() > 0));
            chk("m_mem_addr", mem_addr, q.size() > 0 ? addr_of(q[0].tag, q[0].set) : 64'd0);
            chk("m_mem_data", mem_data, q.size() > 0 ? q[0].data : 64'd0);
            chk("m_lookup_hit", 64'(lookup_hit), 64'(e_hit));
            chk("m_lookup_data", lookup_data, e_ld);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic fire(input int t, input int s, input logic [63:0] d, input bit dirty);
        fired_valid = 1;
        fired_tag   = TB'(t);
        fired_set   = SB'(s);
        fired_data  = d;
        fired_dirty = dirty;
    endtask

    task automatic nofire();
        fired_valid = 0;
        fired_dirty = 0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_count", 64'(count), 0);
        chk("rst_fired_ready", 64'(fired_ready), 1);
        chk("rst_valid", 64'(mem_req_valid), 0);
        cyc(); cyc();
        reset = 1;
        cyc();

        // single writeback with stall
        fire(5, 2, 64'hDEAD, 1);
        cyc();
        nofire();
        chk("sw_valid", 64'(mem_req_valid), 1);
        chk("sw_addr", mem_addr, 64'hA10);
        chk("sw_data", mem_data, 64'hDEAD);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("sw_hold_addr", mem_addr, 64'hA10);
            chk("sw_hold_valid", 64'(mem_req_valid), 1);
        end
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        chk("sw_done_count", 64'(count), 0);
        chk("sw_done_valid", 64'(mem_req_valid), 0);

        // clean drop
        fire(6, 1, 64'h1234, 0);
        cyc();
        nofire();
        chk("clean_count", 64'(count), 0);
        chk("clean_valid", 64'(mem_req_valid), 0);

        // fill, overflow reject, drain, refill across the wrap
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 4; k++) begin
                fire(k + 4 * r, 0, 64'(100 + k), 1);
                cyc();
            end
            chk("full_ready", 64'(fired_ready), 0);
            chk("full_count", 64'(count), 4);
            fire(9 + 4 * r, 0, 64'h99, 1);
            cyc();
            nofire();
            chk("full_reject_count", 64'(count), 4);
            mem_req_ready = 1;
            for (int k = 1; k <= 4; k++) begin
                chk("drain_addr", mem_addr, 64'((k + 4 * r) * 512));
                cyc();
            end
            mem_req_ready = 0;
            chk("drain_count", 64'(count), 0);
        end

        // forwarding, newest wins
        lookup_tag = 7;
        lookup_set = 3;
        fire(7, 3, 64'hAAAA, 1);
        #1 chk("fwd_enq_invisible", 64'(lookup_hit), 0);
        cyc();
        fire(7, 3, 64'hBBBB, 1);
        #1 chk("fwd_old_data", lookup_data, 64'hAAAA);
        cyc();
        nofire();
        chk("fwd_hit", 64'(lookup_hit), 1);
        chk("fwd_newest", lookup_data, 64'hBBBB);
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        chk("fwd_after1", lookup_data, 64'hBBBB);
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;
        chk("fwd_after2_hit", 64'(lookup_hit), 0);
        chk("fwd_after2_data", lookup_data, 0);

        // simultaneous enqueue/dequeue
        for (int k = 10; k <= 13; k++) begin
            fire(k, 0, 64'(k), 1);
            cyc();
        end
        mem_req_ready = 1;
        fire(14, 0, 64'd14, 1);
        #1 chk("sim_full_ready", 64'(fired_ready), 0);
        cyc();
        nofire();
        chk("sim_reject_count", 64'(count), 3);
        cyc(); cyc();
        chk("sim_one_count", 64'(count), 1);
        fire(15, 1, 64'hF15, 1);
        cyc();
        nofire();
        mem_req_ready = 0;
        chk("sim_swap_count", 64'(count), 1);
        chk("sim_swap_valid", 64'(mem_req_valid), 1);
        chk("sim_swap_addr", mem_addr, 64'h1E08);
        chk("sim_swap_data", mem_data, 64'hF15);
        mem_req_ready = 1;
        cyc();
        mem_req_ready = 0;

        // async reset mid-send
        lookup_tag = 20;
        lookup_set = 0;
        fire(20, 0, 64'h20, 1);
        cyc();
        fire(21, 0, 64'h21, 1);
        cyc();
        nofire();
        chk("ar_pre_count", 64'(count), 2);
        @(posedge clock);
        #3 reset = 0;
        #1;
        chk("ar_count", 64'(count), 0);
        chk("ar_valid", 64'(mem_req_valid), 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_data", mem_data, 0);
        chk("ar_ready", 64'(fired_ready), 1);
        chk("ar_hit", 64'(lookup_hit), 0);
        cyc(); cyc();
        reset = 1;
        cyc(); cyc(); cyc();
        chk("ar_no_replay_valid", 64'(mem_req_valid), 0);
        chk("ar_no_replay_count", 64'(count), 0);

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
